ifetch_pq: RTL and testbench
============================

# ifetch_pq

Parametrised instruction-fetch unit with a prefetch queue, successor to the single-entry fetch stage. It sits between the instruction SRAM (synchronous, 1-cycle read latency) and decode. It issues sequential word fetches ahead of demand into a FQ_DEPTH-entry queue, and hands {pc, instr} to decode over a valid/ready handshake. On an execute-stage redirect it discards queued and in-flight fetches, then restarts at the redirect target.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, byte address of the first fetched instruction after reset.
- ADDR_W, 10, word-address width of the instruction memory (imem_addr).
- FQ_DEPTH, 2, prefetch queue entries; power of two, ≥ 2.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- imem_req  output  1  read strobe / chip select to instruction SRAM.
- imem_addr  output  ADDR_W  word address, = fetch_pc[ADDR_W+1:2].
- imem_rdata  input  32  read data, valid the cycle after the accepted request.
- redir_valid  input  1  execute-stage redirect (taken branch/jump).
- redir_pc  input  32  redirect target; bits [1:0] ignored (treated as 00).
- f_valid  output  1  queue head holds a valid instruction.
- f_ready  input  1  decode accepts the head this cycle.
- f_instr  output  32  head instruction.
- f_pc  output  32  head instruction's byte address.
- fq_level  output  $clog2(FQ_DEPTH)+1  current queue occupancy (debug/perf).

## Operation
- State: fetch_pc (32b), inflight flag plus its pc, queue of FQ_DEPTH {pc, instr} entries with rd/wr pointers and count.
- Credit rule: issue when count + inflight < FQ_DEPTH, or when a pop (f_valid && f_ready) occurs in the same cycle.
  - imem_req = rst_n && (redir_valid || credit).
  - imem_addr is combinational: redir_valid ? redir_pc : fetch_pc.
- On an accepted request:
  - fetch_pc ← request address + 4, modulo 2^32.
  - inflight ← 1, and the request pc is latched.
- Response: on the edge after issue, imem_rdata and the latched pc are pushed at the queue tail, unless killed by a redirect. inflight clears unless a new request was issued.
- Pop: on f_valid && f_ready the head advances. Push and pop in the same cycle is legal at any occupancy, including full.
- Redirect (redir_valid=1), at the next edge:
  - the queue is emptied;
  - any in-flight response is dropped;
  - the request at redir_pc issued this cycle becomes the sole in-flight fetch;
  - fetch_pc ← redir_pc + 4.
  - f_valid/f_ready in the redirect cycle is don't-care for the fetch unit; decode discards it.
- Back-to-back redirects: only the latest target survives.
- Address aliasing: pc above 2^(ADDR_W+2) wraps into memory via address truncation. f_pc always carries the full 32-bit pc.

## Timing
- Reset values (async): f_valid=0, f_pc=0, f_instr=0, fq_level=0, queue empty, inflight=0, fetch_pc=RESET_PC. imem_req=0 while rst_n=0.
- First edge after reset release (E0): request RESET_PC. E1: push into queue. f_valid=1 after E1, with f_pc=RESET_PC.
- Fetch-to-decode latency is 2 edges. Redirect penalty: first target instruction is presented 2 cycles after the redirect cycle.
- Sustained throughput with f_ready held high: 1 instruction/cycle.
- f_ready low: the queue fills to FQ_DEPTH, and imem_req stays low while full with nothing in flight.
  - The queue never overflows, because inflight counts against credit.
- Outputs f_valid, f_instr, f_pc are registered, driven directly from queue storage.
- Only imem_req/imem_addr have combinational paths, from redir_valid/redir_pc and f_ready.
- Reset asserted mid-operation: all state clears immediately, and no push is taken on the release edge.

## Structure
- Package ifetch_pkg: XLEN=32, INSTR_BYTES=4, pc/instr entry struct type, RESET_PC default constant.
- Sub-module fetch_fifo: generic FQ_DEPTH × (2·XLEN) synchronous FIFO with push/pop/flush, count and simultaneous push+pop at full. ifetch_pq owns credit, pc and kill logic.
- Instruction SRAM stays external to the block.

## Test plan
- Reset release, f_ready=1, RESET_PC=0 → f_pc sequence 0,4,8,C… one per cycle from cycle 2; imem_req continuously high.
- f_ready=0 for 10 cycles after reset, FQ_DEPTH=4 → fq_level saturates at 4, imem_req low, no lost/duplicated pc when f_ready returns (0,4,8,C,10…).
- redir_valid with redir_pc=0x100 while queue full and a fetch in flight → next f_valid presents pc 0x100 two cycles later; no stale pc appears.
- Redirects to 0x200 then 0x300 on consecutive cycles → first delivered pc 0x300.
- redir_pc=0x103, ADDR_W=10 → f_pc=0x100. Fetch_pc at 0xFFC → next imem_addr 0, f_pc 0x1000.
- Assert rst_n low mid-stream with f_valid=1 → f_valid=0 asynchronously; after release the sequence restarts at RESET_PC.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the prefetching instruction fetch unit.
package ifetch_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with flush; push and pop may coincide at any
// occupancy, including full.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [W-1:0]             i_data,
    input  logic                     i_pop,
    output logic                     o_valid,
    output logic [W-1:0]             o_data,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [CW-1:0] r_cnt;

    logic w_pop;
    logic w_push;

    assign w_pop  = i_pop && (r_cnt != '0);
    assign w_push = i_push && ((r_cnt != CW'(DEPTH)) || w_pop);

    assign o_valid = (r_cnt != '0);
    assign o_data  = r_mem[r_rd];
    assign o_count = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else if (i_flush) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= r_wr + AW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + AW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/ifetch_pq.sv
// Instruction fetch with a prefetch queue: credit-based sequential
// prefetch from a 1-cycle SRAM, redirect kill, valid/ready to decode.
module ifetch_pq
    import ifetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
    parameter int              ADDR_W   = 10,
    parameter int              FQ_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    output logic                      imem_req,
    output logic [ADDR_W-1:0]         imem_addr,
    input  logic [XLEN-1:0]           imem_rdata,
    input  logic                      redir_valid,
    input  logic [XLEN-1:0]           redir_pc,
    output logic                      f_valid,
    input  logic                      f_ready,
    output logic [XLEN-1:0]           f_instr,
    output logic [XLEN-1:0]           f_pc,
    output logic [$clog2(FQ_DEPTH):0] fq_level
);

    localparam int              CW    = $clog2(FQ_DEPTH) + 1;
    localparam logic [CW:0]     LIMIT = (CW + 1)'(FQ_DEPTH);
    localparam logic [XLEN-1:0] STEP  = XLEN'(INSTR_BYTES);
    localparam logic [XLEN-1:0] ALIGN = ~XLEN'(INSTR_BYTES - 1);

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_req_pc;
    logic            r_inflight;

    logic [XLEN-1:0] w_req_pc;
    logic [CW:0]     w_occ;
    logic            w_pop;
    logic            w_credit;
    logic            w_push;
    fq_entry_t       w_in;
    fq_entry_t       w_head;

    assign w_req_pc = redir_valid ? (redir_pc & ALIGN) : r_fetch_pc;
    assign w_pop    = f_valid && f_ready;
    // In-flight fetch already owns a slot, so it counts against credit.
    assign w_occ    = {1'b0, fq_level} + (CW + 1)'(r_inflight);
    assign w_credit = (w_occ < LIMIT) || w_pop;

    assign imem_req  = rst_n && (redir_valid || w_credit);
    assign imem_addr = w_req_pc[ADDR_W+1:2];

    assign w_push = r_inflight && !redir_valid;
    assign w_in   = '{pc: r_req_pc, instr: imem_rdata};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= imem_req;
            if (imem_req) begin
                r_fetch_pc <= w_req_pc + STEP;
                r_req_pc   <= w_req_pc;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FQ_DEPTH),
        .W     ($bits(fq_entry_t))
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (redir_valid),
        .i_push  (w_push),
        .i_data  (w_in),
        .i_pop   (w_pop),
        .o_valid (f_valid),
        .o_data  (w_head),
        .o_count (fq_level)
    );

    assign f_pc    = w_head.pc;
    assign f_instr = w_head.instr;

endmodule

// File: tb/tb_ifetch_pq.sv
// Bench for ifetch_pq: directed scenarios plus random redirect/stall
// traffic, checked against an in-order pc stream model.
module tb_ifetch_pq;

    localparam int AW = 10;
    localparam int D  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              imem_req;
    logic [AW-1:0]     imem_addr;
    logic [31:0]       imem_rdata;
    logic              redir_valid;
    logic [31:0]       redir_pc;
    logic              f_valid;
    logic              f_ready;
    logic [31:0]       f_instr;
    logic [31:0]       f_pc;
    logic [$clog2(D):0] fq_level;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_pc;
    int          k;
    logic        last_req;
    logic [31:0] last_addr;
    logic [31:0] last_lvl;

    ifetch_pq #(
        .RESET_PC (32'h0),
        .ADDR_W   (AW),
        .FQ_DEPTH (D)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .f_valid     (f_valid),
        .f_ready     (f_ready),
        .f_instr     (f_instr),
        .f_pc        (f_pc),
        .fq_level    (fq_level)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [AW-1:0] a);
        return 32'hC0DE_0000 ^ {a, 6'h2A, ~a, 6'h15};
    endfunction

    always @(posedge clk) begin
        if (imem_req) imem_rdata <= memf(imem_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rv, input logic [31:0] rpc,
                        input logic rdy);
        logic v;
        logic [31:0] ea;
        @(negedge clk);
        redir_valid = rv;
        redir_pc    = rpc;
        f_ready     = rdy;
        #1;
        v         = f_valid;
        last_req  = imem_req;
        last_addr = 32'(imem_addr);
        last_lvl  = 32'(fq_level);
        chk("f_valid", 32'(v), 32'(k >= 2));
        chk("level_bound", 32'(fq_level <= D), 32'd1);
        chk("level_vs_valid", 32'(fq_level != 0), 32'(v));
        if (v) begin
            ea = exp_pc;
            chk("f_pc", f_pc, ea);
            chk("f_instr", f_instr, memf(ea[AW+1:2]));
        end
        if (rv) begin
            ea = rpc;
            chk("redir_req", 32'(imem_req), 32'd1);
            chk("redir_addr", 32'(imem_addr), 32'(ea[AW+1:2]));
        end else if (k == 0) begin
            ea = exp_pc;
            chk("first_req", 32'(imem_req), 32'd1);
            chk("first_addr", 32'(imem_addr), 32'(ea[AW+1:2]));
        end else if (fq_level <= D - 2) begin
            chk("credit_req", 32'(imem_req), 32'd1);
        end else if (fq_level == D && !rdy) begin
            chk("full_noreq", 32'(imem_req), 32'd0);
        end
        @(posedge clk);
        if (rv) begin
            exp_pc = rpc & ~32'h3;
            k      = 1;
        end else begin
            if (v && rdy) exp_pc = exp_pc + 32'd4;
            if (k < 2) k++;
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        redir_valid = 1'b0;
        redir_pc    = '0;
        f_ready     = 1'b1;
        imem_rdata  = '0;
        exp_pc      = '0;
        k           = 0;
        #3;
        chk("rst_valid", 32'(f_valid), 32'd0);
        chk("rst_pc", f_pc, 32'd0);
        chk("rst_instr", f_instr, 32'd0);
        chk("rst_level", 32'(fq_level), 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1);

        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0);
        chk("sat_level", last_lvl, D);
        chk("sat_req", 32'(last_req), 32'd0);

        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);
        for (int i = 0; i < 2; i++) step(1'b0, '0, 1'b0);
        step(1'b1, 32'h100, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);

        step(1'b1, 32'h200, 1'b1);
        step(1'b1, 32'h300, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);

        step(1'b1, 32'h103, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);

        step(1'b1, 32'hFFC, 1'b1);
        step(1'b0, '0, 1'b1);
        chk("wrap_addr", last_addr, 32'd0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);

        for (int i = 0; i < 400; i++) begin
            step(($urandom % 12) == 0, $urandom,
                 ($urandom % 3) != 0);
        end

        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
        @(negedge clk);
        redir_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(f_valid), 32'd0);
        chk("mid_rst_level", 32'(fq_level), 32'd0);
        chk("mid_rst_req", 32'(imem_req), 32'd0);
        chk("mid_rst_pc", f_pc, 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        exp_pc = '0;
        k      = 0;
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
